// File: rtl/adc_stream_out.sv
// adc_stream_out: streams a completed capture buffer out over valid/ready, with replay support.
// Ports:
//   adc_clock, reset            - clock and synchronous active-high reset
//   capture_done, start_readout - readout request, honoured only while a capture is complete
//   read_addr / read_data       - buffer read port (one-cycle registered read latency)
//   m_data, m_valid, m_ready    - output stream; m_last marks the sample from address DEPTH-1
//   readout_busy, readout_done  - high while streaming / after the final transfer
module adc_stream_out #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  adc_clock,
    input  logic                  reset,
    input  logic                  capture_done,
    input  logic                  start_readout,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  readout_busy,
    output logic                  readout_done
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] ISSUE_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] XFER_LAST = (ADDR_WIDTH+1)'(DEPTH-1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   xfer_cnt_q, xfer_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic [1:0]            last_q, last_d;
    logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic                  pop, start, issue;
    logic [1:0]            occ;

    assign read_addr    = read_addr_q;
    assign m_valid      = count_q != 2'd0;
    assign m_data       = mem_q[rd_ptr_q];
    assign m_last       = m_valid && last_q[rd_ptr_q];
    assign readout_busy = state_q == STREAM;
    assign readout_done = state_q == DONE;

    always_comb begin
        pop             = m_valid && m_ready;
        start           = start_readout && capture_done && state_q != STREAM;
        // Occupancy once this cycle's pop and in-flight return settle; a read issued now
        // lands one edge later, so keeping this below 2 guarantees the FIFO never overflows
        // while still allowing one issue per cycle under full throughput.
        occ             = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue           = state_q == STREAM && occ < 2'd2 && issue_cnt_q != ISSUE_MAX;
        state_d         = pop && xfer_cnt_q == XFER_LAST ? DONE : state_q;
        mem_d           = mem_q;
        last_d          = last_q;
        if (inflight_q) begin
            mem_d[wr_ptr_q]  = read_data;
            last_d[wr_ptr_q] = inflight_last_q;
        end
        wr_ptr_d        = wr_ptr_q ^ inflight_q;
        rd_ptr_d        = rd_ptr_q ^ pop;
        count_d         = occ;
        xfer_cnt_d      = xfer_cnt_q + {{ADDR_WIDTH{1'b0}}, pop};
        issue_cnt_d     = issue_cnt_q + {{ADDR_WIDTH{1'b0}}, issue};
        read_addr_d     = issue && !(&read_addr_q) ? read_addr_q + 1'b1 : read_addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && (&read_addr_q);
        if (start) begin
            state_d         = STREAM;
            read_addr_d     = '0;
            issue_cnt_d     = '0;
            xfer_cnt_d      = '0;
            count_d         = '0;
            rd_ptr_d        = 1'b0;
            wr_ptr_d        = 1'b0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
        end
    end

    always_ff @(posedge adc_clock) begin
        if (reset) begin
            state_q         <= IDLE;
            read_addr_q     <= '0;
            issue_cnt_q     <= '0;
            xfer_cnt_q      <= '0;
            mem_q           <= '{default: '0};
            last_q          <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            read_addr_q     <= read_addr_d;
            issue_cnt_q     <= issue_cnt_d;
            xfer_cnt_q      <= xfer_cnt_d;
            mem_q           <= mem_d;
            last_q          <= last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end
endmodule

// File: tb/tb_adc_stream_out.sv
// tb_adc_stream_out: directed bench for adc_stream_out against a registered-read buffer model.
module tb_adc_stream_out;
    logic        adc_clock = 1'b0;
    logic        reset = 1'b1;
    logic        capture_done = 1'b0;
    logic        start_readout = 1'b0;
    logic        m_ready = 1'b0;
    logic [11:0] read_addr, read_data, m_data;
    logic        m_valid, m_last, readout_busy, readout_done;
    logic [11:0] mem [4096];
    int          checks = 0;
    int          failures = 0;

    adc_stream_out dut (
        .adc_clock(adc_clock), .reset(reset), .capture_done(capture_done),
        .start_readout(start_readout), .read_addr(read_addr), .read_data(read_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .readout_busy(readout_busy), .readout_done(readout_done)
    );

    always #5 adc_clock = ~adc_clock;
    always @(posedge adc_clock) read_data <= mem[read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(read_addr), 0);
        check({tag, "_data"}, 32'(m_data), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_last"}, 32'(m_last), 0);
        check({tag, "_busy"}, 32'(readout_busy), 0);
        check({tag, "_done"}, 32'(readout_done), 0);
    endtask

    // Starts a readout and consumes it. pct: m_ready probability; hold: initial cycles of
    // m_ready=0; stop_at: sample index to stall on and return early (-1 for full run);
    // mid: issue a stray start and drop capture_done partway through.
    task automatic run(input int pct, input int hold, input int stop_at, input bit mid);
        int     exp_idx = 0;
        int     cyc = 0;
        bit     stalled = 0;
        logic [11:0] held = '0;
        m_ready = (hold == 0 && pct == 100);
        start_readout = 1'b1;
        @(negedge adc_clock);
        start_readout = 1'b0;
        check("start_busy", 32'(readout_busy), 1);
        check("start_addr", 32'(read_addr), 0);
        check("start_valid_k", 32'(m_valid), 0);
        @(negedge adc_clock);
        check("start_valid_k1", 32'(m_valid), 0);
        @(negedge adc_clock);
        check("start_valid_k2", 32'(m_valid), 1);
        while (exp_idx < 4096 && cyc < 20000) begin
            start_readout = 1'b0;
            capture_done = !(mid && exp_idx >= 3000 && exp_idx < 3100);
            if (stalled) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(held));
            end
            if (pct == 100 && hold == 0) check("no_bubble", 32'(m_valid), 1);
            if (m_valid) begin
                check("data", 32'(m_data), exp_idx);
                check("last", 32'(m_last), 32'(exp_idx == 4095));
            end
            if (stop_at >= 0 && exp_idx == stop_at && m_valid) begin
                m_ready = 1'b0;
                return;
            end
            if (hold > 0 && cyc == hold) check("hold_addr_le2", 32'(read_addr <= 12'd2), 1);
            m_ready = cyc < hold ? 1'b0 : ($urandom_range(99) < pct);
            if (mid && exp_idx == 2000) start_readout = 1'b1;
            stalled = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) exp_idx++;
            cyc++;
            @(negedge adc_clock);
        end
        start_readout = 1'b0;
        capture_done = 1'b1;
        check("count", exp_idx, 4096);
        if (pct == 100 && hold == 0) check("cycles", cyc, 4096);
        check("end_valid", 32'(m_valid), 0);
        check("end_done", 32'(readout_done), 1);
        check("end_busy", 32'(readout_busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'(i);
        repeat (3) @(negedge adc_clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        start_readout = 1'b1;
        @(negedge adc_clock);
        start_readout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("idle_busy", 32'(readout_busy), 0);
            check("idle_valid", 32'(m_valid), 0);
            check("idle_addr", 32'(read_addr), 0);
            @(negedge adc_clock);
        end
        capture_done = 1'b1;
        run(100, 0, -1, 1'b0);
        run(50, 0, -1, 1'b1);
        run(100, 10, -1, 1'b0);
        run(100, 0, 100, 1'b0);
        reset = 1'b1;
        @(negedge adc_clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        @(negedge adc_clock);
        check_reset_outputs("postreset");
        run(100, 0, -1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_stream_out.md
# adc_stream_out

Downstream stage of the ADC capture buffer. Once a capture has completed, it walks the buffer's read port from address 0 to DEPTH-1 and streams each sample out on a valid/ready interface, with `m_last` marking the final sample. It absorbs the buffer's one-cycle read latency and tolerates arbitrary sink backpressure. It feeds the team's packetiser/UART path, and it can replay the same capture any number of times.

## Interface
- `DATA_WIDTH`, default 12: sample width. Matches the capture buffer.
- `ADDR_WIDTH`, default 12: buffer address width.
- `DEPTH`, default 4096: number of samples streamed per readout. Must equal 2^ADDR_WIDTH.

- `adc_clock` in 1: the only clock. Shared with the capture buffer.
- `reset` in 1: synchronous, active-high reset.
- `capture_done` in 1: level from the capture stage. High means the buffer holds a complete capture.
- `start_readout` in 1: request to stream the buffer. Sampled on each rising edge.
- `read_addr` out ADDR_WIDTH: registered address driven to the buffer read port.
- `read_data` in DATA_WIDTH: buffer output. Valid one cycle after `read_addr` is presented (registered read).
- `m_data` out DATA_WIDTH: streamed sample.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: sink accepts. A transfer occurs on a cycle where `m_valid && m_ready`.
- `m_last` out 1: qualifies the sample from address DEPTH-1.
- `readout_busy` out 1: high in STREAM.
- `readout_done` out 1: high in DONE.

## Operation
- States:
  - IDLE → STREAM on `start_readout && capture_done`. `start_readout` without `capture_done` is ignored.
  - STREAM → DONE on the transfer with `m_last=1`.
  - DONE → STREAM on `start_readout && capture_done`. This replays from address 0.
  - `start_readout` during STREAM is ignored.
- Internal 2-entry skid FIFO holds samples returned from the buffer. `m_data`/`m_valid`/`m_last` come from the FIFO head.
- Read issue:
  - One read is issued per cycle while (FIFO occupancy + reads in flight) < 2 and the issue count is < DEPTH.
  - `read_addr` increments by 1 after each issued read, up to DEPTH-1.
  - It does not wrap within a readout. It returns to 0 on entry to STREAM and on reset.
- The sample returning for an issued read is written into the FIFO on the following edge, tagged `last` when its address was DEPTH-1.
- Counters:
  - Issue counter is ADDR_WIDTH+1 bits (0..DEPTH).
  - Transfer counter is ADDR_WIDTH+1 bits.
  - No arithmetic is performed on sample data. `m_data` equals the stored word bit-for-bit.
- `capture_done` falling during STREAM is ignored, and the current readout completes.
- Backpressure:
  - While `m_valid && !m_ready`, `m_data` and `m_last` hold stable.
  - `m_valid` does not drop until the transfer occurs.
- Exactly DEPTH transfers per readout.
- No sample is duplicated or skipped, including across any `m_ready` toggling pattern.

## Timing
- Reset values (all outputs): `read_addr`=0, `m_data`=0, `m_valid`=0, `m_last`=0, `readout_busy`=0, `readout_done`=0. FIFO is emptied, counters are 0, and the state is IDLE.
- Reset has priority over all other inputs, including mid-STREAM. After the reset edge, all outputs are at reset values and no further read is issued.
- Startup latency:
  - `start_readout` accepted at edge k: `readout_busy`=1 after edge k.
  - `read_addr`=0 is presented during cycle k→k+1.
  - The first sample enters the FIFO at edge k+2, so `m_valid`=1 with `m_data`=mem[0] after edge k+2.
- Throughput: with `m_ready` held at 1, one transfer per cycle with no bubbles. Last transfer at edge k+2+DEPTH.
- After the `m_last` transfer at edge t:
  - `m_valid`=0 and `readout_done`=1 after edge t.
  - `readout_busy`=0 after edge t.
- When `m_ready` deasserts, at most 2 samples are buffered and no read is issued that would overflow the FIFO.
- Resume after backpressure: a transfer occurs on the same cycle `m_ready` returns high. Throughput is back to 1/cycle within 1 cycle.

## Test plan
- Preload mem[i]=i (12-bit), `capture_done`=1, pulse `start_readout`, hold `m_ready`=1 → 4096 transfers with values 0..4095 in order. First `m_valid` 2 cycles after start. `m_last` only on 4095. `readout_done`=1 after.
- Same preload, `m_ready` random ~50% → identical 4096-value sequence. `m_data` stable during every stall. No gaps or duplicates.
- `start_readout` with `capture_done`=0 → stays IDLE, `m_valid`=0, `read_addr`=0 for 20 cycles.
- Assert `reset` after 100 transfers (`m_ready` stalled on sample 100) → next cycle all outputs at reset values. A new start then streams again from value 0.
- From DONE, pulse `start_readout` again → full replay 0..4095. A `start_readout` pulse mid-stream is ignored, with the count still exactly 4096.
- `m_ready`=0 from start for 10 cycles → `read_addr` advances to at most 2. First transfer carries 0 when `m_ready` rises, then 1 per cycle.
